word_frame_tx: RTL
==================

Name: word_frame_tx

Overview:
- Transmit-side framer for the 16-bit serial-word link. It feeds the serializer, and its output goes to the far-end receiver's word aligner.
- After PHY_INIT it emits a burst of sync words so the receiver can find word alignment.
- It then streams payload words from a small internal FIFO, one word per TX_EN slot, and inserts idle fill when the FIFO is empty.

Parameters:
- SYNC_WORD, 16'hF731, alignment pattern sent during the sync burst.
- SYNC_CNT, 8, number of sync words per burst; legal range 1..255.
- IDLE_WORD, 16'h0000, fill word sent in DATA state when the FIFO is empty.
- FIFO_AW, 2, log2 of FIFO depth (default depth 4).

Ports:
- RSTX  input  1  asynchronous active-low reset.
- CLK  input  1  clock.
- PHY_INIT  input  1  synchronous restart pulse: flush FIFO, start sync burst.
- TX_EN  input  1  output slot strobe from the serializer; one word is emitted per strobe.
- DIPUSH  input  1  payload write strobe.
- DIN  input  16  payload word.
- FULL  output  1  FIFO full; a DIPUSH while FULL is dropped.
- OVERFLOW  output  1  sticky: a write was dropped.
- DOPUSH  output  1  output word valid (registered).
- DOUT  output  16  output word (registered).
- LINK_UP  output  1  high while in DATA state.

Behaviour:
- Reset is RSTX, asynchronous, active-low; clock is CLK.
- Reset values:
  - state=IDLE, FIFO empty, sync counter=0.
  - DOPUSH=0, DOUT=16'd0.
  - FULL=0, OVERFLOW=0, LINK_UP=0.
- State machine IDLE / SYNC / DATA:
  - IDLE: no output; TX_EN is ignored and DOPUSH stays 0. The FIFO accepts writes. PHY_INIT -> SYNC.
  - SYNC: each TX_EN emits SYNC_WORD and increments the counter. On the TX_EN that emits sync word number SYNC_CNT, go to DATA next cycle.
  - DATA: each TX_EN pops the FIFO head and emits it if the FIFO is non-empty; otherwise it emits IDLE_WORD. Remains in DATA until PHY_INIT.
- PHY_INIT, from any state:
  - Highest priority: next state SYNC, counter cleared, FIFO pointers and count cleared, OVERFLOW cleared.
  - A DIPUSH or TX_EN in the same cycle is discarded; DOPUSH=0 the following cycle.
- Output timing:
  - DOPUSH and DOUT are registered: DOPUSH(t+1) is 1 iff TX_EN(t) was accepted in SYNC or DATA.
  - DOUT holds its last value when DOPUSH=0.
  - Latency from TX_EN to DOPUSH is 1 cycle.
- FIFO:
  - Depth 2^FIFO_AW, circular read/write pointers with wrap-around at depth-1 -> 0, plus a count register (FIFO_AW+1 bits).
  - FULL = (count == depth), combinational from registered count.
- DIPUSH handling:
  - DIPUSH with FULL=1 drops the word and sets OVERFLOW. This holds even if a pop occurs in the same cycle, because FULL is evaluated before the pop.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - Push to an empty FIFO while a pop occurs in the same cycle: there is no bypass, so IDLE_WORD is emitted and the word is stored (count becomes 1).
- Word order out equals DIPUSH order; no reordering or duplication.
- LINK_UP = (state == DATA), registered with the state.
- Sync counter is 8 bits; SYNC_CNT=1 produces exactly one sync word.
- Reset asserted mid-burst or mid-stream returns everything to reset values immediately; FIFO contents are lost.

Test Plan:
1. Reset, then TX_EN every cycle for 10 cycles, no PHY_INIT -> DOPUSH stays 0, LINK_UP=0.
2. PHY_INIT pulse, then TX_EN every cycle -> exactly 8 words of 16'hF731 with DOPUSH, starting 1 cycle after the first TX_EN. Then LINK_UP=1 and DOUT=16'h0000 fill words follow.
3. In DATA, push 16'h1234, 16'h5678, 16'h9ABC; then TX_EN every other cycle -> DOUT sequence 1234, 5678, 9ABC, 0000. No drops.
4. In DATA with no TX_EN, push 5 words 0001..0005 -> FULL=1 after the 4th, 5th dropped, OVERFLOW=1. Then 5 TX_EN -> 0001..0004, 0000.
5. Loopback: output fed through a 0..15-bit shifted stream into the word aligner -> receiver aligns during the burst and recovers the payload 1234, 5678 intact.
6. PHY_INIT while the FIFO holds 2 words in DATA, with DIPUSH the same cycle -> FIFO empty, OVERFLOW=0, LINK_UP=0. Next TX_EN emits F731 and the restart burst is a full 8 words.

Source files
------------

// File: rtl/word_frame_tx.sv
// Transmit framer for the 16-bit serial-word link: sync burst after PHY_INIT,
// then payload words from a small FIFO with idle fill when empty.
module word_frame_tx #(
  parameter logic [15:0] SYNC_WORD = 16'hF731,
  parameter int unsigned SYNC_CNT  = 8,
  parameter logic [15:0] IDLE_WORD = 16'h0000,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic        RSTX,
  input  logic        CLK,
  input  logic        PHY_INIT,
  input  logic        TX_EN,
  input  logic        DIPUSH,
  input  logic [15:0] DIN,
  output logic        FULL,
  output logic        OVERFLOW,
  output logic        DOPUSH,
  output logic [15:0] DOUT,
  output logic        LINK_UP
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           sync_cnt;
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count;
  logic [15:0]          mem [DEPTH];

  logic        emit, pop, push, ovf_set, sync_inc;
  logic [15:0] dout_d;

  assign FULL    = (count == (FIFO_AW + 1)'(DEPTH));
  assign LINK_UP = (state_q == ST_DATA);

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // PHY_INIT overrides everything, so every strobe is qualified with it here.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    pop      = 1'b0;
    sync_inc = 1'b0;
    dout_d   = IDLE_WORD;
    push     = DIPUSH && !FULL && !PHY_INIT;
    ovf_set  = DIPUSH && FULL && !PHY_INIT;
    case (state_q)
      ST_SYNC: begin
        if (TX_EN) begin
          emit     = 1'b1;
          sync_inc = 1'b1;
          dout_d   = SYNC_WORD;
          if (sync_cnt == 8'(SYNC_CNT - 1)) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (TX_EN) begin
          emit = 1'b1;
          if (count != '0) begin
            pop    = 1'b1;
            dout_d = mem[rd_ptr];
          end
        end
      end
      default: ;
    endcase
    if (PHY_INIT) begin
      state_d  = ST_SYNC;
      emit     = 1'b0;
      pop      = 1'b0;
      sync_inc = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      sync_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
      DOPUSH   <= 1'b0;
      DOUT     <= '0;
    end else if (PHY_INIT) begin
      sync_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
      DOPUSH   <= 1'b0;
    end else begin
      DOPUSH <= emit;
      if (emit)     DOUT     <= dout_d;
      if (sync_inc) sync_cnt <= sync_cnt + 8'd1;
      if (ovf_set)  OVERFLOW <= 1'b1;
      if (push)     wr_ptr   <= wr_ptr + FIFO_AW'(1);
      if (pop)      rd_ptr   <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= DIN;
  end

endmodule
